// File: rtl/baud_tick_generator_if.sv
// Control/status bundle between the baud tick generator and the UART engines.
// The master drives divisor programming and phase control; the generator returns the tick strobes.
interface baud_tick_if #(
    parameter int DIV_W  = 16,
    parameter int FRAC_W = 4,
    parameter int PH_W   = 4
);
    logic              en;
    logic [DIV_W-1:0]  div_int;
    logic [FRAC_W-1:0] div_frac;
    logic              div_load;
    logic              rx_restart;
    logic              rx_tick;
    logic              tx_tick;
    logic [PH_W-1:0]   os_phase;
    logic              div_err;

    modport master (
        output en, div_int, div_frac, div_load, rx_restart,
        input  rx_tick, tx_tick, os_phase, div_err
    );

    modport slave (
        input  en, div_int, div_frac, div_load, rx_restart,
        output rx_tick, tx_tick, os_phase, div_err
    );
endinterface

// File: rtl/baud_tick_generator.sv
// Fractional-N baud tick generator: oversampled rx_tick and bit-rate tx_tick clock enables,
// with a shadow-buffered runtime divisor and start-bit re-phasing via rx_restart.
module baud_tick_generator #(
    parameter int CLK_FREQ    = 10_000_000,
    parameter int OVERSAMPLE  = 16,
    parameter int DIV_W       = 16,
    parameter int FRAC_W      = 4,
    parameter int DEFAULT_DIV = 65,
    localparam int PH_W       = $clog2(OVERSAMPLE)
) (
    input  logic          clk,
    input  logic          rst,
    baud_tick_if.slave    bus
);

    // Reject parameterisations the counter arithmetic cannot honour.
    if (OVERSAMPLE < 2 || DEFAULT_DIV < 2 || CLK_FREQ <= 0) begin : g_param_check
        $error("baud_tick_generator: illegal parameter set");
    end

    logic [DIV_W-1:0]  cnt_r;
    logic [FRAC_W-1:0] acc_r;
    logic [PH_W-1:0]   os_cnt_r;
    logic [DIV_W-1:0]  act_int_r;
    logic [FRAC_W-1:0] act_frac_r;
    logic [DIV_W-1:0]  sh_int_r;
    logic [FRAC_W-1:0] sh_frac_r;
    logic              pend_r;
    logic              rx_tick_r;
    logic              tx_tick_r;
    logic              div_err_r;

    logic [DIV_W-1:0]  sel_int_s;
    logic [FRAC_W-1:0] sel_frac_s;
    logic [DIV_W-1:0]  rs_int_s;
    logic [FRAC_W-1:0] rs_frac_s;
    logic [FRAC_W:0]   frac_sum_s;
    logic              load_ok_s;
    logic              boundary_s;
    logic              os_wrap_s;

    // Divisor selection for the period boundary and for a restart (which sees a same-cycle load).
    always_comb begin
        sel_int_s  = act_int_r;
        sel_frac_s = act_frac_r;
        rs_int_s   = act_int_r;
        rs_frac_s  = act_frac_r;
        load_ok_s  = bus.div_load && (bus.div_int >= DIV_W'(2));
        if (pend_r) begin
            sel_int_s  = sh_int_r;
            sel_frac_s = sh_frac_r;
        end else begin
            sel_int_s  = act_int_r;
            sel_frac_s = act_frac_r;
        end
        if (load_ok_s) begin
            rs_int_s  = bus.div_int;
            rs_frac_s = bus.div_frac;
        end else begin
            rs_int_s  = sel_int_s;
            rs_frac_s = sel_frac_s;
        end
        frac_sum_s = {1'b0, acc_r} + {1'b0, sel_frac_s};
        boundary_s = bus.en && (cnt_r == {DIV_W{1'b0}});
        os_wrap_s  = (os_cnt_r == PH_W'(OVERSAMPLE - 1));
    end

    // Period counter, fractional accumulator, oversample phase, divisor registers and strobes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_r      <= DIV_W'(DEFAULT_DIV - 1);
            acc_r      <= {FRAC_W{1'b0}};
            os_cnt_r   <= {PH_W{1'b0}};
            act_int_r  <= DIV_W'(DEFAULT_DIV);
            act_frac_r <= {FRAC_W{1'b0}};
            sh_int_r   <= DIV_W'(DEFAULT_DIV);
            sh_frac_r  <= {FRAC_W{1'b0}};
            pend_r     <= 1'b0;
            rx_tick_r  <= 1'b0;
            tx_tick_r  <= 1'b0;
            div_err_r  <= 1'b0;
        end else begin
            if (bus.rx_restart) begin
                act_int_r  <= rs_int_s;
                act_frac_r <= rs_frac_s;
                pend_r     <= 1'b0;
                cnt_r      <= rs_int_s - DIV_W'(1);
                acc_r      <= {FRAC_W{1'b0}};
                os_cnt_r   <= {PH_W{1'b0}};
                rx_tick_r  <= 1'b0;
                tx_tick_r  <= 1'b0;
            end else if (boundary_s) begin
                // The accumulator carry stretches this period by one clock.
                cnt_r      <= sel_int_s - DIV_W'(1)
                              + {{(DIV_W-1){1'b0}}, frac_sum_s[FRAC_W]};
                acc_r      <= frac_sum_s[FRAC_W-1:0];
                act_int_r  <= sel_int_s;
                act_frac_r <= sel_frac_s;
                pend_r     <= 1'b0;
                rx_tick_r  <= 1'b1;
                tx_tick_r  <= os_wrap_s;
                os_cnt_r   <= os_wrap_s ? {PH_W{1'b0}} : (os_cnt_r + PH_W'(1));
            end else if (bus.en) begin
                cnt_r      <= cnt_r - DIV_W'(1);
                rx_tick_r  <= 1'b0;
                tx_tick_r  <= 1'b0;
            end else begin
                rx_tick_r  <= 1'b0;
                tx_tick_r  <= 1'b0;
            end

            if (load_ok_s) begin
                sh_int_r  <= bus.div_int;
                sh_frac_r <= bus.div_frac;
                pend_r    <= ~bus.rx_restart;
                div_err_r <= 1'b0;
            end else if (bus.div_load) begin
                div_err_r <= 1'b1;
            end else begin
                div_err_r <= div_err_r;
            end
        end
    end

    assign bus.rx_tick  = rx_tick_r;
    assign bus.tx_tick  = tx_tick_r;
    assign bus.os_phase = os_cnt_r;
    assign bus.div_err  = div_err_r;

endmodule

// File: doc/baud_tick_generator.md
# baud_tick_generator

Runtime-programmable fractional-N baud tick generator, successor to the fixed four-rate baud generator. Emits single-cycle clock-enable strobes, not derived clocks: `rx_tick` at the oversampled rate and `tx_tick` at the bit rate. It sits between the system clock domain and the UART Rx/Tx engines. The divisor is loadable at any time, has a fractional part for low baud error, and `rx_restart` re-phases the oversample counter on a start-bit edge.

## Interface
- `CLK_FREQ`, 10_000_000: system clock in Hz; documentation and bench use only, no RTL effect.
- `OVERSAMPLE`, 16: rx_ticks per tx_tick; must be ≥ 2.
- `DIV_W`, 16: width of the integer divisor.
- `FRAC_W`, 4: width of the fractional divisor (units of 1/2^FRAC_W clock).
- `DEFAULT_DIV`, 65: integer divisor after reset (10 MHz / (9600·16) ≈ 65); must be ≥ 2.
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  reset; asynchronous, active-low.
- `en`  in  1  count enable; low freezes all state.
- `div_int`  in  DIV_W  integer cycles per rx_tick; valid range 2 … 2^DIV_W−1.
- `div_frac`  in  FRAC_W  fractional cycles per rx_tick.
- `div_load`  in  1  one-cycle strobe; captures `div_int` and `div_frac` into the shadow registers.
- `rx_restart`  in  1  one-cycle strobe; restarts the rx/tx phase.
- `rx_tick`  out  1  one-cycle strobe at the oversampled rate.
- `tx_tick`  out  1  one-cycle strobe at the bit rate, coincident with every OVERSAMPLE-th rx_tick.
- `os_phase`  out  $clog2(OVERSAMPLE)  index of the current rx_tick within the bit.
- `div_err`  out  1  sticky flag: the last `div_load` was rejected.

## Operation
- State:
  - `cnt` [DIV_W]: period down-counter.
  - `acc` [FRAC_W]: fractional accumulator.
  - `os_cnt`: oversample counter.
  - Active divisor `act_int` / `act_frac`.
  - Shadow divisor `sh_int` / `sh_frac`, plus `pend` flag.
- Reset values:
  - `cnt` = DEFAULT_DIV−1; `acc` = 0; `os_cnt` = 0.
  - `act_int` = `sh_int` = DEFAULT_DIV; `act_frac` = `sh_frac` = 0; `pend` = 0.
  - Outputs `rx_tick` = 0, `tx_tick` = 0, `os_phase` = 0, `div_err` = 0.
- `en` = 0: all counters, accumulator and `pend` hold; `rx_tick` and `tx_tick` are driven 0. `div_load` is still accepted.
- Enabled cycle, `cnt` ≠ 0: `cnt` decrements; ticks are 0.
- Enabled cycle, `cnt` = 0 (the boundary):
  - Let `{c, acc'} = acc + frac`, where `int`/`frac` are the shadow values if `pend`, otherwise the active values.
  - `cnt` ← `int` − 1 + c; `acc` ← `acc'`.
  - If `pend`: active ← shadow and `pend` ← 0.
  - `rx_tick` ← 1.
  - `os_cnt` ← (`os_cnt` = OVERSAMPLE−1) ? 0 : `os_cnt`+1.
  - `tx_tick` ← 1 iff `os_cnt` was OVERSAMPLE−1.
- Result: the rx_tick period is `int` or `int`+1 cycles. The long-run mean is `int` + `frac`/2^FRAC_W, and the error never accumulates beyond one clock.
- `div_load`:
  - If `div_int` ≥ 2: shadow ← inputs, `pend` ← 1, `div_err` ← 0.
  - If `div_int` < 2: ignored, `div_err` ← 1; shadow, active and `pend` are unchanged.
  - The divisor never changes mid-period and no period is truncated.
- `rx_restart` (priority over the boundary and over `en`):
  - Active ← shadow if `pend`; `pend` ← 0.
  - `cnt` ← `act_int`−1, using the post-update value; `acc` ← 0; `os_cnt` ← 0.
  - Ticks are 0 that cycle.
- `div_load` and `rx_restart` in the same cycle: the new divisor is applied immediately (restart sees the freshly loaded shadow). A rejected load leaves restart using the old divisor.
- `os_phase` = `os_cnt`, registered.

## Timing
- Ticks are registered: asserted for exactly one cycle, on the edge after the `cnt` = 0 cycle.
- First rx_tick after reset release: high during the cycle following the DEFAULT_DIV-th rising edge. Subsequent spacing is D cycles for an integer divisor D.
- First tx_tick: coincident with the OVERSAMPLE-th rx_tick after reset or restart.
- `rx_restart` at edge E: next rx_tick follows edge E + `act_int`.
- `div_load` latency: takes effect at the next period boundary. The current period completes with the old divisor.
- Reset asserted mid-operation: all state returns to its reset values asynchronously, and any pending load is discarded.

## Test plan
- Reset, `en` = 1, no loads:
  - rx_tick every 65 cycles, tx_tick on every 16th rx_tick.
  - `os_phase` runs 0…15 then wraps.
  - All outputs 0 during reset.
- `div_load`, int = 10, frac = 8 (FRAC_W = 4): rx_tick spacing alternates 10, 11, giving 21 cycles per 2 ticks over ≥ 32 ticks.
- `div_load`, int = 20, issued 5 cycles into a 65-cycle period: that period still measures 65, every later period measures 20.
- `div_load` with int = 1:
  - `div_err` = 1 and the period stays unchanged.
  - A following valid load clears `div_err`.
- `rx_restart` at `os_phase` = 9:
  - `os_phase` = 0; next rx_tick after exactly `act_int` cycles.
  - tx_tick 16 rx_ticks later.
  - Combined with a same-cycle `div_load` of 30, the next tick comes after 30 cycles.
- `en` low for 40 cycles mid-period: no ticks, remaining count preserved. Reset pulsed mid-period: ticks stop immediately and the first-tick timing restarts from DEFAULT_DIV.
